// File: rtl/pot_scanner_pkg.sv
// Shared definitions for the pot scanner slice.
// Holds the A2D result and channel-select widths, the default slot-to-channel
// map and the scanner state encoding. No ports.
package pot_pkg;

    localparam int RES_W    = 12;   // A2D conversion result width
    localparam int CHN_W    = 3;    // A2D channel-select width
    localparam int MAX_CHNL = 8;    // largest number of slots a sweep can hold

    // Slot-to-channel map, 3 bits per slot with slot 0 in the LSBs.
    // Slots 0..5 map to channels 0,1,3,4,7,0; slots 6..7 are unused.
    localparam logic [MAX_CHNL*CHN_W-1:0] DFLT_CHNL_MAP =
        {3'd0, 3'd0, 3'd0, 3'd7, 3'd4, 3'd3, 3'd1, 3'd0};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

endpackage

// File: rtl/pot_scanner_if.sv
// A2D handshake bundle between the pot scanner and the converter front end.
//   strt_cnv  : one-cycle conversion request (scanner -> A2D)
//   chnnl     : channel select, held through the conversion (scanner -> A2D)
//   cnv_cmplt : one-cycle conversion-done pulse (A2D -> scanner)
//   res       : conversion result, valid while cnv_cmplt is high (A2D -> scanner)
interface pot_scanner_if;
    import pot_pkg::*;

    logic             strt_cnv;
    logic [CHN_W-1:0] chnnl;
    logic             cnv_cmplt;
    logic [RES_W-1:0] res;

    // Scanner side: issues requests, consumes results.
    modport master (
        output strt_cnv,
        output chnnl,
        input  cnv_cmplt,
        input  res
    );

    // Converter side: consumes requests, returns results.
    modport slave (
        input  strt_cnv,
        input  chnnl,
        output cnv_cmplt,
        output res
    );

endinterface

// File: rtl/pot_timeout.sv
// Conversion watchdog for the pot scanner.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : return the count to zero
//   run      : count one cycle per clock while high
//   expired  : high in the cycle the count sits at TIMEOUT_CYC-1 while running,
//              i.e. on the TIMEOUT_CYC-th consecutive running cycle
module pot_timeout #(
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    assign expired = run && (cnt_r == CNT_LAST);

    // Cycle counter; it parks at the last value so it never wraps back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (run && !expired) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/pot_scanner.sv
// Potentiometer scanner: sweeps NUM_CHNL slots through an A2D converter and
// keeps a deadbanded gain per slot.
//   clk, rst  : clock and asynchronous active-high reset
//   en        : scan enable, looked at only between sweeps
//   a2d       : A2D handshake (strt_cnv/chnnl out, cnv_cmplt/res in)
//   gain      : packed per-slot gains, slot k at [k*GAIN_W +: GAIN_W]
//   scan_done : one-cycle pulse after the last slot of a sweep is processed
//   all_valid : sticky, every slot has been written at least once
//   err       : sticky, some conversion timed out
module pot_scanner import pot_pkg::*; #(
    parameter int                          NUM_CHNL    = 6,
    parameter logic [MAX_CHNL*CHN_W-1:0]   CHNL_MAP    = DFLT_CHNL_MAP,
    parameter int                          GAIN_W      = 13,
    parameter int                          DEADBAND    = 4,
    parameter int                          TIMEOUT_CYC = 2048
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    pot_scanner_if.master              a2d,
    output logic [NUM_CHNL*GAIN_W-1:0] gain,
    output logic                       scan_done,
    output logic                       all_valid,
    output logic                       err
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] START  = ST_START;
    localparam logic [1:0] WAIT   = ST_WAIT;
    localparam logic [1:0] UPDATE = ST_UPDATE;

    localparam int                SLOT_W    = 3;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHNL - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = 3'd1;
    localparam logic [RES_W:0]    DB_V      = (RES_W + 1)'(DEADBAND);

    logic [1:0]          state_r, state_nxt_s;
    logic [SLOT_W-1:0]   slot_r, slot_nxt_s;
    logic [RES_W-1:0]    res_r;
    logic                cap_ok_r;
    logic [GAIN_W-1:0]   gain_r [NUM_CHNL];
    logic [NUM_CHNL-1:0] written_r, wr_mask_s, written_nxt_s;
    logic                strt_r, scan_done_r, all_valid_r, err_r;
    logic [CHN_W-1:0]    chnnl_r;
    logic                run_s, clr_s, expired_s, cmplt_s;
    logic                last_s, write_s, big_s;
    logic signed [RES_W:0] diff_s;
    logic [RES_W:0]      mag_s;

    assign run_s   = (state_r == WAIT);
    assign clr_s   = !run_s;
    assign cmplt_s = run_s && a2d.cnv_cmplt;
    assign last_s  = (slot_r == LAST_SLOT);

    pot_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .run     (run_s),
        .expired (expired_s)
    );

    // Deadband test: the difference is taken one bit wider than the result so
    // that e.g. 0x001 vs 0xFFF reads as a large step, not a wrapped small one.
    always_comb begin
        diff_s = $signed({1'b0, res_r}) - $signed({1'b0, gain_r[slot_r][RES_W-1:0]});
        if (diff_s[RES_W]) begin
            mag_s = {(RES_W + 1){1'b0}} - $unsigned(diff_s);
        end else begin
            mag_s = $unsigned(diff_s);
        end
        big_s   = (mag_s >= DB_V);
        write_s = (state_r == UPDATE) && cap_ok_r && (!written_r[slot_r] || big_s);
    end

    // One-hot write strobe for the slot being updated.
    always_comb begin
        for (int k = 0; k < NUM_CHNL; k++) begin
            wr_mask_s[k] = write_s && (slot_r == SLOT_W'(k));
        end
        written_nxt_s = written_r | wr_mask_s;
    end

    // Next-state and next-slot decode.
    always_comb begin
        state_nxt_s = state_r;
        slot_nxt_s  = slot_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = START;
                    slot_nxt_s  = {SLOT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (cmplt_s || expired_s) begin
                    state_nxt_s = UPDATE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            UPDATE: begin
                if (last_s) begin
                    slot_nxt_s  = {SLOT_W{1'b0}};
                    state_nxt_s = en ? START : IDLE;
                end else begin
                    slot_nxt_s  = slot_r + SLOT_ONE;
                    state_nxt_s = START;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                slot_nxt_s  = {SLOT_W{1'b0}};
            end
        endcase
    end

    // FSM state, slot index and the registered A2D request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            slot_r  <= {SLOT_W{1'b0}};
            strt_r  <= 1'b0;
            chnnl_r <= {CHN_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            slot_r  <= slot_nxt_s;
            strt_r  <= (state_nxt_s == START);
            if (state_nxt_s == START) begin
                chnnl_r <= CHNL_MAP[slot_nxt_s*CHN_W +: CHN_W];
            end else begin
                chnnl_r <= chnnl_r;
            end
        end
    end

    // Result capture; a completion on the expiry cycle takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_r    <= {RES_W{1'b0}};
            cap_ok_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (cmplt_s) begin
                res_r    <= a2d.res;
                cap_ok_r <= 1'b1;
            end else if (expired_s) begin
                res_r    <= res_r;
                cap_ok_r <= 1'b0;
            end else begin
                res_r    <= res_r;
                cap_ok_r <= cap_ok_r;
            end
            err_r <= err_r | (expired_s & ~cmplt_s);
        end
    end

    // Gain storage and written flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CHNL; k++) begin
                gain_r[k] <= {GAIN_W{1'b0}};
            end
            written_r <= {NUM_CHNL{1'b0}};
        end else begin
            for (int k = 0; k < NUM_CHNL; k++) begin
                if (wr_mask_s[k]) begin
                    gain_r[k] <= {{(GAIN_W - RES_W){1'b0}}, res_r};
                end else begin
                    gain_r[k] <= gain_r[k];
                end
            end
            written_r <= written_nxt_s;
        end
    end

    // End-of-sweep pulse and sticky all-valid (counts this cycle's write too).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_done_r <= 1'b0;
            all_valid_r <= 1'b0;
        end else begin
            scan_done_r <= (state_r == UPDATE) && last_s;
            all_valid_r <= all_valid_r |
                           ((state_r == UPDATE) && last_s && (&written_nxt_s));
        end
    end

    for (genvar k = 0; k < NUM_CHNL; k++) begin : g_gain_out
        assign gain[k*GAIN_W +: GAIN_W] = gain_r[k];
    end

    assign a2d.strt_cnv = strt_r;
    assign a2d.chnnl    = chnnl_r;
    assign scan_done    = scan_done_r;
    assign all_valid    = all_valid_r;
    assign err          = err_r;

endmodule

// File: tb/tb_pot_scanner.sv
// Self-checking bench for pot_scanner: directed sweeps (first sweep, deadband,
// wrap-free difference, timeout, completion/expiry collision, en drop, reset
// mid-conversion) plus randomized sweeps against a behavioural gain model.
module tb_pot_scanner;

    localparam int NCH  = 6;
    localparam int GW   = 13;
    localparam int DB   = 4;
    localparam int TO   = 2048;
    localparam int LAST = NCH - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NCH*GW-1:0] gain;
    logic            scan_done;
    logic            all_valid;
    logic            err;

    pot_scanner_if a2d_if ();

    pot_scanner #(
        .NUM_CHNL    (NCH),
        .GAIN_W      (GW),
        .DEADBAND    (DB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a2d       (a2d_if),
        .gain      (gain),
        .scan_done (scan_done),
        .all_valid (all_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural model of the stored state.
    int exp_chn [NCH] = '{0, 1, 3, 4, 7, 0};
    int m_gain  [NCH];
    bit m_wr    [NCH];
    bit m_err;
    bit m_valid;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] g(input int k);
        return 32'(gain[k*GW +: GW]);
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < NCH; k++) begin
            m_gain[k] = 0;
            m_wr[k]   = 1'b0;
        end
        m_err   = 1'b0;
        m_valid = 1'b0;
    endfunction

    function automatic void m_update(input int s, input int v);
        int d;
        d = v - m_gain[s];
        if (d < 0) d = -d;
        if (!m_wr[s] || d >= DB) begin
            m_gain[s] = v;
            m_wr[s]   = 1'b1;
        end
    endfunction

    function automatic void m_sweep_end();
        bit all = 1'b1;
        for (int k = 0; k < NCH; k++) if (!m_wr[k]) all = 1'b0;
        if (all) m_valid = 1'b1;
    endfunction

    function automatic int rnd_res(input int s);
        int v;
        if ($urandom_range(0, 1) == 0) begin
            v = int'($urandom_range(0, 4095));
        end else begin
            v = m_gain[s] + int'($urandom_range(0, 12)) - 6;
            if (v < 0) v = 0;
            if (v > 4095) v = 4095;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strt(input int s);
        int n = 0;
        while (a2d_if.strt_cnv !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk($sformatf("strt_s%0d", s), 32'(a2d_if.strt_cnv), 32'd1);
        chk($sformatf("chnnl_s%0d", s), 32'(a2d_if.chnnl), 32'(exp_chn[s]));
    endtask

    // Called in the cycle after UPDATE of slot s.
    task automatic end_of_update(input int s);
        chk($sformatf("gain_s%0d", s), g(s), 32'(m_gain[s]));
        chk($sformatf("err_s%0d", s), 32'(err), 32'(m_err));
        if (s == LAST) begin
            m_sweep_end();
            chk("scan_done_last", 32'(scan_done), 32'd1);
        end else begin
            chk($sformatf("scan_done_s%0d", s), 32'(scan_done), 32'd0);
        end
        chk($sformatf("all_valid_s%0d", s), 32'(all_valid), 32'(m_valid));
    endtask

    // Answer one request: cnv_cmplt is high in the dly-th WAIT cycle.
    task automatic convert(input int s, input int dly, input int v);
        wait_strt(s);
        tick();
        chk("strt_pulse", 32'(a2d_if.strt_cnv), 32'd0);
        repeat (dly - 1) tick();
        a2d_if.cnv_cmplt = 1'b1;
        a2d_if.res       = 12'(v);
        tick();
        a2d_if.cnv_cmplt = 1'b0;
        a2d_if.res       = 12'($urandom);
        chk($sformatf("gain_hold_s%0d", s), g(s), 32'(m_gain[s]));
        m_update(s, v);
        tick();
        end_of_update(s);
    endtask

    // Withhold cnv_cmplt entirely for slot s.
    task automatic timeout_slot(input int s);
        wait_strt(s);
        repeat (TO) tick();
        chk("err_before_expiry", 32'(err), 32'(m_err));
        tick();
        m_err = 1'b1;
        chk("err_after_expiry", 32'(err), 32'd1);
        tick();
        end_of_update(s);
    endtask

    // Idle after a sweep: stray completion ignored, no new request or pulse.
    task automatic idle_check(input string tag);
        int hits = 0;
        a2d_if.cnv_cmplt = 1'b1;
        a2d_if.res       = 12'hABC;
        tick();
        a2d_if.cnv_cmplt = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a2d_if.strt_cnv === 1'b1 || scan_done === 1'b1) hits++;
            tick();
        end
        chk(tag, 32'(hits), 32'd0);
        for (int k = 0; k < NCH; k++) chk($sformatf("%s_gain%0d", tag, k), g(k), 32'(m_gain[k]));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_strt"}, 32'(a2d_if.strt_cnv), 32'd0);
        chk({tag, "_chnnl"}, 32'(a2d_if.chnnl), 32'd0);
        chk({tag, "_scan_done"}, 32'(scan_done), 32'd0);
        chk({tag, "_all_valid"}, 32'(all_valid), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        for (int k = 0; k < NCH; k++) chk($sformatf("%s_gain%0d", tag, k), g(k), 32'd0);
    endtask

    initial begin
        int stop_slot;
        rst = 1'b1;
        en  = 1'b0;
        a2d_if.cnv_cmplt = 1'b0;
        a2d_if.res       = 12'h000;
        m_reset();
        repeat (3) tick();
        chk_reset("por");
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_no_strt", 32'(a2d_if.strt_cnv), 32'd0);

        // Sweep 1: 40-cycle answers, res = slot*0x100.
        en = 1'b1;
        for (int s = 0; s < NCH; s++) convert(s, 40, s * 256);

        // Sweep 2: within-deadband step, large value, collision on expiry cycle.
        convert(0, int'($urandom_range(1, 80)), rnd_res(0));
        convert(1, 5, 12'hFFF);
        convert(2, 17, 12'h203);
        chk("deadband_hold", g(2), 32'h200);
        convert(3, int'($urandom_range(1, 80)), rnd_res(3));
        convert(4, TO, 12'hABC);
        chk("collision_gain", g(4), 32'hABC);
        convert(5, int'($urandom_range(1, 80)), rnd_res(5));

        // Sweep 3: en drops at slot 1, no-wrap difference, deadband edge, timeout.
        convert(0, int'($urandom_range(1, 80)), rnd_res(0));
        en = 1'b0;
        convert(1, 3, 12'h001);
        convert(2, 9, 12'h204);
        chk("deadband_edge", g(2), 32'h204);
        timeout_slot(3);
        convert(4, int'($urandom_range(1, 80)), rnd_res(4));
        convert(5, int'($urandom_range(1, 80)), rnd_res(5));
        idle_check("en_drop_idle");

        // Randomized sweeps; en dropped somewhere in the last one.
        en = 1'b1;
        stop_slot = int'($urandom_range(0, LAST));
        for (int sw = 0; sw < 4; sw++) begin
            for (int s = 0; s < NCH; s++) begin
                if (sw == 3 && s == stop_slot) en = 1'b0;
                convert(s, int'($urandom_range(1, 80)), rnd_res(s));
            end
        end
        idle_check("rand_idle");

        // Reset during WAIT, then a stray completion.
        en = 1'b1;
        wait_strt(0);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk_reset("rst_async");
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        a2d_if.cnv_cmplt = 1'b1;
        a2d_if.res       = 12'h777;
        tick();
        a2d_if.cnv_cmplt = 1'b0;
        repeat (3) tick();
        chk_reset("rst_stray");
        m_reset();

        // Written flags cleared by reset: a small first result is still stored.
        en = 1'b1;
        convert(0, 7, 2);
        en = 1'b0;
        for (int s = 1; s < NCH; s++) convert(s, int'($urandom_range(1, 80)), rnd_res(s));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
